// File: rtl/freq_meas_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module   : freq_meas_scheduler_if
//  Purpose  : Result-posting handshake between the frequency measurement
//             scheduler and its consumer.
//  Ports    : out_valid   - result available (scheduler -> consumer)
//             out_ready   - consumer accepts result (consumer -> scheduler)
//             out_channel - channel of the posted result
//             out_result  - averaged period in clk cycles, 0 on timeout
//             out_timeout - result ended by timeout
//  Revision : 1.0  initial release
// ============================================================================
interface freq_meas_scheduler_if #(
   parameter int CHW = 2
);
   logic           out_valid;
   logic           out_ready;
   logic [CHW-1:0] out_channel;
   logic [31:0]    out_result;
   logic           out_timeout;

   modport master (
      output out_valid,
      output out_channel,
      output out_result,
      output out_timeout,
      input  out_ready
   );

   modport slave (
      input  out_valid,
      input  out_channel,
      input  out_result,
      input  out_timeout,
      output out_ready
   );
endinterface
`default_nettype wire

// File: rtl/freq_meas_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : freq_meas_scheduler
//  Purpose  : Round-robin scheduler that multiplexes NCH asynchronous
//             frequency inputs onto one shared averaging period detector,
//             bounds each measurement with an edge count or an idle timeout,
//             and posts one result per channel over a valid/ready handshake.
//  Ports    : clk, reset_n      - clock, synchronous active-low reset
//             enable            - run scheduling (0: finish channel, idle)
//             ch_mask           - per-channel measurement enable
//             divisor           - log2 of periods averaged (clamped to 7)
//             timeout           - max clk cycles between edges (0 = off)
//             freq_in           - asynchronous frequency inputs
//             det_reset_n       - detector reset, active-low
//             det_signal        - synchronized selected channel
//             det_divisor       - divisor driven to the detector
//             det_result        - averaged period from the detector
//             res               - result handshake (master side)
//  Revision : 1.0  initial release
// ============================================================================
module freq_meas_scheduler #(
   parameter int NCH = 4,
   parameter int CHW = 2
) (
   input  wire logic                clk,
   input  wire logic                reset_n,
   input  wire logic                enable,
   input  wire logic [NCH-1:0]      ch_mask,
   input  wire logic [7:0]          divisor,
   input  wire logic [31:0]         timeout,
   input  wire logic [NCH-1:0]      freq_in,
   output      logic                det_reset_n,
   output      logic                det_signal,
   output      logic [7:0]          det_divisor,
   input  wire logic [31:0]         det_result,
   freq_meas_scheduler_if.master    res
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_FLUSH   = 3'd1,
      S_MEASURE = 3'd2,
      S_CAPTURE = 3'd3,
      S_POST    = 3'd4
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;

   logic [NCH-1:0]  r_sync1;
   logic [NCH-1:0]  r_sync2;
   logic            r_sig_d;
   logic [CHW-1:0]  r_ch;
   logic [CHW-1:0]  r_last;
   logic [2:0]      r_eff_div;
   logic            r_flush_cnt;
   logic [8:0]      r_edge_cnt;
   logic [31:0]     r_idle_cnt;
   logic [31:0]     r_result;
   logic            r_timeout_flag;
   logic [CHW-1:0]  r_out_ch;

   logic            w_edge;
   logic [8:0]      w_target;
   logic [CHW-1:0]  w_base;
   logic [CHW-1:0]  w_sel;
   logic            w_idle_expired;
   logic            w_det_rst_n;
   logic            w_valid;

   assign det_signal  = r_sync2[r_ch];
   assign w_edge      = det_signal & ~r_sig_d;
   assign w_target    = (9'd1 << r_eff_div) + 9'd2;
   assign det_divisor = {5'd0, r_eff_div};

   // The idle counter is about to hit the limit this cycle; widened by one
   // bit so a timeout of all-ones cannot wrap.
   assign w_idle_expired = (timeout != 32'd0) && !w_edge &&
                           (({1'b0, r_idle_cnt} + 33'd1) >= {1'b0, timeout});

   // In POST the channel being posted is about to become the last-served one,
   // so the search for the following channel starts from it directly.
   assign w_base = (r_state == S_POST) ? r_ch : r_last;

   // Round-robin search: walk downwards so the nearest set bit after w_base
   // is the final assignment.
   always_comb begin
      int idx;
      w_sel = w_base;
      for (int k = NCH; k >= 1; k--) begin
         idx = (int'(w_base) + k) % NCH;
         if (ch_mask[idx]) begin
            w_sel = CHW'(idx);
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_det_rst_n = 1'b1;
      w_valid     = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_det_rst_n = 1'b0;
            if (enable && (ch_mask != '0)) begin
               w_state_nxt = S_FLUSH;
            end
         end
         S_FLUSH: begin
            w_det_rst_n = 1'b0;
            if (r_flush_cnt) begin
               w_state_nxt = S_MEASURE;
            end
         end
         S_MEASURE: begin
            if (w_edge && (r_edge_cnt == w_target - 9'd1)) begin
               w_state_nxt = S_CAPTURE;
            end else if (w_idle_expired) begin
               w_state_nxt = S_POST;
            end
         end
         S_CAPTURE: begin
            w_state_nxt = S_POST;
         end
         S_POST: begin
            w_valid = 1'b1;
            if (res.out_ready) begin
               w_state_nxt = (enable && (ch_mask != '0)) ? S_FLUSH : S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_det_rst_n = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state        <= S_IDLE;
         r_sync1        <= '0;
         r_sync2        <= '0;
         r_sig_d        <= 1'b0;
         r_ch           <= '0;
         r_last         <= CHW'(NCH - 1);
         r_eff_div      <= 3'd0;
         r_flush_cnt    <= 1'b0;
         r_edge_cnt     <= 9'd0;
         r_idle_cnt     <= 32'd0;
         r_result       <= 32'd0;
         r_timeout_flag <= 1'b0;
         r_out_ch       <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_sync1 <= freq_in;
         r_sync2 <= r_sync1;
         r_sig_d <= det_signal;

         if ((w_state_nxt == S_FLUSH) && (r_state != S_FLUSH)) begin
            r_ch        <= w_sel;
            r_eff_div   <= (divisor > 8'd7) ? 3'd7 : divisor[2:0];
            r_flush_cnt <= 1'b0;
         end

         case (r_state)
            S_FLUSH: begin
               r_flush_cnt <= 1'b1;
               r_edge_cnt  <= 9'd0;
               r_idle_cnt  <= 32'd0;
            end
            S_MEASURE: begin
               if (w_edge) begin
                  r_edge_cnt <= r_edge_cnt + 9'd1;
                  r_idle_cnt <= 32'd0;
               end else begin
                  r_idle_cnt <= r_idle_cnt + 32'd1;
               end
               if (w_state_nxt == S_POST) begin
                  r_result       <= 32'd0;
                  r_timeout_flag <= 1'b1;
                  r_out_ch       <= r_ch;
               end
            end
            S_CAPTURE: begin
               r_result       <= det_result;
               r_timeout_flag <= 1'b0;
               r_out_ch       <= r_ch;
            end
            S_POST: begin
               if (res.out_ready) begin
                  r_last <= r_ch;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign det_reset_n     = w_det_rst_n;
   assign res.out_valid   = w_valid;
   assign res.out_channel = r_out_ch;
   assign res.out_result  = r_result;
   assign res.out_timeout = r_timeout_flag;

endmodule
`default_nettype wire

// File: tb/tb_freq_meas_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_freq_meas_scheduler
//  Purpose  : Self-checking bench for freq_meas_scheduler. Generates periodic
//             channel signals, models the shared averaging detector, and
//             predicts channel order, results and measurement lengths.
//  Revision : 1.0  initial release
// ============================================================================
module tb_freq_meas_scheduler;
   localparam int NCH = 4;
   localparam int CHW = 2;

   logic            clk = 1'b0;
   logic            reset_n;
   logic            enable;
   logic [NCH-1:0]  ch_mask;
   logic [7:0]      divisor;
   logic [31:0]     timeout;
   logic [NCH-1:0]  freq_in = '0;
   logic            det_reset_n;
   logic            det_signal;
   logic [7:0]      det_divisor;
   logic [31:0]     det_result;

   freq_meas_scheduler_if #(.CHW(CHW)) res_if ();

   freq_meas_scheduler #(.NCH(NCH), .CHW(CHW)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .enable      (enable),
      .ch_mask     (ch_mask),
      .divisor     (divisor),
      .timeout     (timeout),
      .freq_in     (freq_in),
      .det_reset_n (det_reset_n),
      .det_signal  (det_signal),
      .det_divisor (det_divisor),
      .det_result  (det_result),
      .res         (res_if.master)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int period [NCH];
   int phase  [NCH];
   int exp_last;

   // Channel waveforms: period p cycles, high for p/2; p = 0 means stuck low.
   always @(negedge clk) begin
      for (int c = 0; c < NCH; c++) begin
         if (period[c] == 0) begin
            freq_in[c] = 1'b0;
         end else begin
            phase[c]   = (phase[c] + 1) % period[c];
            freq_in[c] = (phase[c] < period[c] / 2);
         end
      end
   end

   // Detector model (reports the most recent edge-to-edge interval) plus
   // counters of edges and cycles seen while a measurement is in flight.
   int   cyc = 0;
   int   det_last_t;
   int   edge_cnt;
   int   meas_cyc;
   logic prev = 1'b0;

   always @(posedge clk) begin
      cyc  <= cyc + 1;
      prev <= det_signal;
      if (det_reset_n !== 1'b1) begin
         det_result <= 32'd0;
         det_last_t <= -1;
         edge_cnt   <= 0;
         meas_cyc   <= 0;
      end else begin
         if (det_signal && !prev) begin
            if (det_last_t >= 0) det_result <= 32'(cyc - det_last_t);
            det_last_t <= cyc;
         end
         if (res_if.out_valid !== 1'b1) begin
            meas_cyc <= meas_cyc + 1;
            if (det_signal && !prev) edge_cnt <= edge_cnt + 1;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int eff(input int d);
      return (d > 7) ? 7 : d;
   endfunction

   function automatic int next_ch(input logic [NCH-1:0] m, input int last);
      logic [NCH-1:0] mm;
      mm = m;
      for (int k = 1; k <= NCH; k++) begin
         if (mm[(last + k) % NCH]) return (last + k) % NCH;
      end
      return last;
   endfunction

   // Wait (bounded) for the next posted result and check it.
   task automatic wait_post(input int ch, input int div, input bit exp_to, input int tmo);
      int n;
      bit seen;
      bit div_done;
      n = 0; seen = 0; div_done = 0;
      while (!seen && n < 20000) begin
         @(negedge clk);
         n++;
         if (!div_done && det_reset_n === 1'b1 && res_if.out_valid !== 1'b1) begin
            chk("det_divisor", {24'd0, det_divisor}, 32'(eff(div)));
            div_done = 1;
         end
         if (res_if.out_valid === 1'b1) seen = 1;
      end
      chk("post_seen", {31'd0, seen}, 32'd1);
      if (seen) begin
         chk("out_channel", {30'd0, res_if.out_channel}, 32'(ch));
         chk("out_timeout", {31'd0, res_if.out_timeout}, {31'd0, exp_to});
         chk("out_result", res_if.out_result, exp_to ? 32'd0 : 32'(period[ch]));
         if (exp_to) chk("idle_cycles", 32'(meas_cyc), 32'(tmo));
         else        chk("edge_count", 32'(edge_cnt), 32'((1 << eff(div)) + 2));
      end
   endtask

   task automatic accept(input int ch);
      res_if.out_ready = 1'b1;
      @(negedge clk);
      res_if.out_ready = 1'b0;
      exp_last = ch;
   endtask

   task automatic wait_measure();
      int n;
      n = 0;
      while (det_reset_n !== 1'b1 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk("measure_reached", {31'd0, det_reset_n}, 32'd1);
   endtask

   initial begin
      int c;
      int d;
      int nd;
      logic [NCH-1:0] nm;
      logic [31:0] h_res;
      logic [CHW-1:0] h_ch;
      logic h_to;
      bit stable;
      bit woke;

      for (int i = 0; i < NCH; i++) begin period[i] = 0; phase[i] = 0; end
      reset_n = 1'b0; enable = 1'b0; ch_mask = '0; divisor = 8'd0;
      timeout = 32'd0; res_if.out_ready = 1'b0;
      repeat (3) @(negedge clk);

      // Reset state
      chk("rst_out_valid",   {31'd0, res_if.out_valid}, 32'd0);
      chk("rst_out_timeout", {31'd0, res_if.out_timeout}, 32'd0);
      chk("rst_out_result",  res_if.out_result, 32'd0);
      chk("rst_out_channel", {30'd0, res_if.out_channel}, 32'd0);
      chk("rst_det_reset_n", {31'd0, det_reset_n}, 32'd0);
      chk("rst_det_divisor", {24'd0, det_divisor}, 32'd0);
      reset_n  = 1'b1;
      exp_last = NCH - 1;

      // Alternating ch0/ch2 with ready held high
      period[0] = 10; period[2] = 20;
      ch_mask = 4'b0101; divisor = 8'd2; res_if.out_ready = 1'b1;
      repeat (40) @(negedge clk);
      enable = 1'b1;
      for (int i = 0; i < 4; i++) begin
         c = next_ch(ch_mask, exp_last);
         wait_post(c, 2, 1'b0, 0);
         if (i == 3) enable = 1'b0;
         @(negedge clk);
         exp_last = c;
      end
      chk("idle_after_alt", {31'd0, det_reset_n}, 32'd0);
      res_if.out_ready = 1'b0;

      // Backpressure hold, FLUSH timing, single-channel repeat
      period[3] = 8; ch_mask = 4'b1000; divisor = 8'd1;
      repeat (20) @(negedge clk);
      enable = 1'b1;
      wait_post(3, 1, 1'b0, 0);
      h_res = res_if.out_result; h_ch = res_if.out_channel; h_to = res_if.out_timeout;
      stable = 1;
      repeat (50) begin
         @(negedge clk);
         if (res_if.out_valid !== 1'b1 || res_if.out_result !== h_res ||
             res_if.out_channel !== h_ch || res_if.out_timeout !== h_to) stable = 0;
      end
      chk("hold_stable", {31'd0, stable}, 32'd1);
      accept(3);
      chk("flush1_det_reset_n", {31'd0, det_reset_n}, 32'd0);
      chk("flush1_out_valid",   {31'd0, res_if.out_valid}, 32'd0);
      @(negedge clk);
      chk("flush2_det_reset_n", {31'd0, det_reset_n}, 32'd0);
      @(negedge clk);
      chk("measure_det_reset_n", {31'd0, det_reset_n}, 32'd1);
      wait_post(3, 1, 1'b0, 0);
      enable = 1'b0;
      accept(3);

      // Stuck-low channel times out, then is re-measured
      ch_mask = 4'b0010; divisor = 8'd3; timeout = 32'd100;
      repeat (5) @(negedge clk);
      enable = 1'b1;
      wait_post(1, 3, 1'b1, 100);
      accept(1);
      wait_post(1, 3, 1'b1, 100);
      enable = 1'b0;
      accept(1);
      timeout = 32'd0;

      // Divisor above 7 clamps to 7: 130 edges per measurement
      period[1] = 4; divisor = 8'd9;
      repeat (20) @(negedge clk);
      enable = 1'b1;
      wait_post(1, 9, 1'b0, 0);
      enable = 1'b0;
      accept(1);

      // Enable dropped mid-measurement: result still posts, then stays idle
      period[0] = 6; ch_mask = 4'b0001; divisor = 8'd2;
      repeat (20) @(negedge clk);
      enable = 1'b1;
      wait_measure();
      @(negedge clk);
      enable = 1'b0;
      wait_post(0, 2, 1'b0, 0);
      accept(0);
      woke = 0;
      repeat (30) begin
         @(negedge clk);
         if (det_reset_n !== 1'b0 || res_if.out_valid !== 1'b0) woke = 1;
      end
      chk("stay_idle", {31'd0, woke}, 32'd0);

      // Reset mid-measurement: discard, restart at ch0
      period[1] = 4; period[2] = 10; period[3] = 8;
      ch_mask = 4'b1111; divisor = 8'd2;
      repeat (20) @(negedge clk);
      enable = 1'b1;
      wait_measure();
      repeat (3) @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      chk("midrst_out_valid",   {31'd0, res_if.out_valid}, 32'd0);
      chk("midrst_det_reset_n", {31'd0, det_reset_n}, 32'd0);
      chk("midrst_det_divisor", {24'd0, det_divisor}, 32'd0);
      @(negedge clk);
      reset_n  = 1'b1;
      exp_last = NCH - 1;
      wait_post(0, 2, 1'b0, 0);
      enable = 1'b0;
      accept(0);

      // Randomized round-robin with mask/divisor changes while posting
      for (int i = 0; i < NCH; i++) period[i] = int'($urandom_range(4, 24));
      ch_mask = 4'($urandom_range(1, 15));
      d = int'($urandom_range(0, 4));
      divisor = 8'(d);
      timeout = ($urandom_range(0, 1) == 1) ? 32'd500 : 32'd0;
      repeat (40) @(negedge clk);
      enable = 1'b1;
      for (int i = 0; i < 16; i++) begin
         c = next_ch(ch_mask, exp_last);
         wait_post(c, d, 1'b0, 0);
         nm = 4'($urandom_range(1, 15));
         nd = int'($urandom_range(0, 4));
         ch_mask = nm;
         divisor = 8'(nd);
         if (i == 15) enable = 1'b0;
         accept(c);
         d = nd;
      end
      repeat (5) @(negedge clk);
      chk("final_idle", {31'd0, det_reset_n}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire
